// File: rtl/i2c_slave.sv
// I2C target endpoint: START/STOP detection, 7-bit address match, byte-wide
// write/read data paths. SCL is oversampled on clk; SDA is open-drain.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic       rw_dir
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [1:0] ph_q, ph_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  logic scl_rise, scl_fall, start_c, stop_c, sda_in;

  // Synchronisers idle high so a reset never fabricates a bus edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign start_c  = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_c   = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign sda_in   = sda_s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd7;
      sr_q       <= 8'h00;
      ph_q       <= 2'd0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ph_q       <= ph_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  // ph_q sequences the ACK slot (0: await fall, 1: await rise, 2: await
  // release fall) and flags "bit 0 clocked" in READ.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ph_d       = ph_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = 3'd7;
    end else begin
      case (state_q)
        IDLE: oe_d = 1'b0;
        ADDR: begin
          if (scl_rise) begin
            sr_d = {sr_q[6:0], sda_in};
            if (cnt_q == 3'd0) begin
              if (sr_q[6:0] == SLAVE_ADDR) begin
                rw_d    = sda_in;
                busy_d  = 1'b1;
                ph_d    = 2'd0;
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ADDR_ACK, WRITE_ACK: begin
          if (ph_q == 2'd0 && scl_fall) begin
            oe_d = 1'b1;
            ph_d = 2'd1;
          end else if (ph_q == 2'd1 && scl_rise) begin
            ph_d = 2'd2;
          end else if (ph_q == 2'd2 && scl_fall) begin
            oe_d  = 1'b0;
            cnt_d = 3'd7;
            ph_d  = 2'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              sr_d     = tx_data;
              tx_req_d = 1'b1;
              oe_d     = ~tx_data[7];
              state_d  = READ;
            end else begin
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            sr_d = {sr_q[6:0], sda_in};
            if (cnt_q == 3'd0) begin
              rx_data_d  = {sr_q[6:0], sda_in};
              rx_valid_d = 1'b1;
              ph_d       = 2'd0;
              state_d    = WRITE_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        READ: begin
          if (scl_rise) begin
            if (cnt_q == 3'd0) ph_d = 2'd1;
            else               cnt_d = cnt_q - 3'd1;
          end else if (scl_fall) begin
            if (ph_q == 2'd1) begin
              oe_d    = 1'b0;
              ph_d    = 2'd0;
              state_d = READ_ACK;
            end else begin
              oe_d = ~sr_q[cnt_q];
            end
          end
        end
        READ_ACK: begin
          if (ph_q == 2'd0 && scl_rise) begin
            if (!sda_in) ph_d = 2'd1;
            else         state_d = WAIT_STOP;
          end else if (ph_q == 2'd1 && scl_fall) begin
            sr_d     = tx_data;
            tx_req_d = 1'b1;
            oe_d     = ~tx_data[7];
            cnt_d    = 3'd7;
            ph_d     = 2'd0;
            state_d  = READ;
          end
        end
        WAIT_STOP: oe_d = 1'b0;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign rw_dir   = rw_q;

endmodule
